ab_split_fifo: RTL and testbench
================================

AB_SPLIT_FIFO -- requirements
Module: ab_split_fifo

Interface
REQ-001 The module SHALL have parameter W_FIFO, default 8, giving the width of each output operand in bits.
REQ-002 The module SHALL have parameter D_FIFO, default 8, giving the depth in entries of each branch buffer; legal values are powers of two, 2 or greater.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 up_data  input  2*W_FIFO  packed operand pair; bits [2W-1:W] go to operand a and bits [W-1:0] go to operand b.
REQ-006 up_valid  input  1  the upstream word is valid.
REQ-007 up_ready  output  1  the block can accept the upstream word.
REQ-008 down_data_a / down_valid_a / down_ready_a  output W_FIFO / output 1 / input 1  valid-ready stream for operand a.
REQ-009 down_data_b / down_valid_b / down_ready_b  output W_FIFO / output 1 / input 1  valid-ready stream for operand b.

Function
REQ-010 Each branch SHALL hold its own circular buffer of D_FIFO entries, with a write pointer, a read pointer and a full/empty tracker.
REQ-011 up_ready SHALL equal (not full_a) AND (not full_b), and SHALL depend only on registered state, with no combinational path from down_ready_a or down_ready_b.
REQ-012 A push SHALL occur when up_valid and up_ready are both high; the push writes the a-half to buffer a and the b-half to buffer b in the same cycle.
REQ-013 down_valid_x SHALL equal (not empty_x), and down_data_x SHALL present the entry at read pointer x.
REQ-014 A pop of branch x SHALL occur when down_valid_x and down_ready_x are both high; the two branches pop independently.
REQ-015 Latency SHALL be 1 cycle: a word pushed at edge N is visible on both down streams after edge N.
REQ-016 There SHALL be no fall-through path from up_data to down_data.
REQ-017 On a simultaneous push and pop on a non-empty, non-full branch, the occupancy of that branch SHALL be unchanged, and the data SHALL stay correctly ordered.
REQ-018 When either branch is full, up_ready SHALL be low, and no push SHALL occur even if that branch pops in the same cycle.
REQ-019 A pop on an empty branch SHALL be impossible because down_valid is low; down_ready_x SHALL be ignored in that case.
REQ-020 Pointers SHALL wrap from D_FIFO-1 to 0 with no lost or duplicated entry.
REQ-021 While up_valid is high and up_ready is low, the upstream holds up_data stable; the block SHALL accept the word exactly once, when up_ready rises.
REQ-022 Word order SHALL be preserved per branch, and the k-th word on a SHALL pair with the k-th word on b.

Reset
REQ-023 Asserting rst low SHALL immediately and asynchronously clear all pointers and trackers.
REQ-024 During reset, down_valid_a=0, down_valid_b=0 and up_ready=1 (once rst is high, on the first edge).
REQ-025 down_data outputs are don't-care during reset; buffer memory SHALL NOT be reset.
REQ-026 A reset asserted mid-operation SHALL discard all buffered words; after release, the first accepted word SHALL be the first word output.

Configuration
REQ-027 When macro AB_SPLIT_FIFO_COUNT_EN is defined, the module SHALL add outputs count_a and count_b, each $clog2(D_FIFO+1) bits wide, giving registered occupancy in the range 0..D_FIFO, reset to 0.
REQ-028 When AB_SPLIT_FIFO_COUNT_EN is not defined, those ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Post reset, with D_FIFO=8 and W_FIFO=8: expect up_ready=1, down_valid_a=0 and down_valid_b=0.
REQ-030 Push 16'hA55A with both down_ready=1: one cycle later expect down_data_a=8'hA5 and down_data_b=8'h5A with both valids high, then both empty.
REQ-031 Hold down_ready_b=0 and push 8 words while a drains: expect up_ready=0 after the 8th push, down_valid_b=1, and count_b=8 when the macro is defined.
REQ-032 Issue 20 pushes with random, independent down_ready on each branch: expect both output sequences to match the input halves in order, with no loss and correct pointer wrap.
REQ-033 Assert rst low mid-stream with 3 words buffered: expect down_valid low at once; after release, push 16'h0102 and expect 8'h01 and 8'h02 to be the first outputs.

Source files
------------

// File: rtl/ab_split_fifo.sv
// ab_split_fifo: splits each upstream operand pair into two independently drained FIFO streams (a = upper half, b = lower half).
// Define AB_SPLIT_FIFO_COUNT_EN to add registered occupancy outputs count_a / count_b.
module ab_split_fifo #(
  parameter int W_FIFO = 8,
  parameter int D_FIFO = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*W_FIFO-1:0]   up_data,
  input  logic                  up_valid,
  output logic                  up_ready,
  output logic [W_FIFO-1:0]     down_data_a,
  output logic                  down_valid_a,
  input  logic                  down_ready_a,
  output logic [W_FIFO-1:0]     down_data_b,
  output logic                  down_valid_b,
  input  logic                  down_ready_b
`ifdef AB_SPLIT_FIFO_COUNT_EN
  ,
  output logic [$clog2(D_FIFO+1)-1:0] count_a,
  output logic [$clog2(D_FIFO+1)-1:0] count_b
`endif
);
  localparam int AW = $clog2(D_FIFO);
  logic [1:0] full, valid, rdy;
  logic [1:0][W_FIFO-1:0] dout;
  logic push;
  assign rdy = {down_ready_a, down_ready_b};
  assign up_ready = ~|full;
  assign push = up_valid && up_ready;
  assign down_data_a = dout[1];
  assign down_data_b = dout[0];
  assign down_valid_a = valid[1];
  assign down_valid_b = valid[0];
`ifdef AB_SPLIT_FIFO_COUNT_EN
  logic [1:0][$clog2(D_FIFO+1)-1:0] cnt;
  assign count_a = cnt[1];
  assign count_b = cnt[0];
`endif
  // Branch 1 carries the upper half (a), branch 0 the lower half (b); pointers carry a wrap bit to tell full from empty.
  for (genvar g = 0; g < 2; g++) begin : g_br
    logic [W_FIFO-1:0] mem [D_FIFO];
    logic [AW:0] wptr, rptr;
    logic pop;
    assign valid[g] = wptr != rptr;
    assign full[g] = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
    assign pop = valid[g] && rdy[g];
    assign dout[g] = mem[rptr[AW-1:0]];
    always_ff @(posedge clk)
      if (push) mem[wptr[AW-1:0]] <= up_data[g*W_FIFO +: W_FIFO];
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop) rptr <= rptr + 1'b1;
      end
`ifdef AB_SPLIT_FIFO_COUNT_EN
    logic [$clog2(D_FIFO+1)-1:0] occ;
    assign cnt[g] = occ;
    always_ff @(posedge clk or negedge rst)
      if (!rst) occ <= '0;
      else occ <= occ + ($clog2(D_FIFO+1))'(push) - ($clog2(D_FIFO+1))'(pop);
`endif
  end
endmodule

// File: tb/tb_ab_split_fifo.sv
// tb_ab_split_fifo: scoreboard bench for ab_split_fifo; a per-edge monitor models both queues and checks every pop.
module tb_ab_split_fifo;
  localparam int W = 8;
  localparam int D = 8;
  logic clk, rst;
  logic [2*W-1:0] up_data;
  logic up_valid, up_ready;
  logic [W-1:0] down_data_a, down_data_b;
  logic down_valid_a, down_ready_a, down_valid_b, down_ready_b;
`ifdef AB_SPLIT_FIFO_COUNT_EN
  logic [$clog2(D+1)-1:0] count_a, count_b;
`endif
  int errors = 0;
  int checks = 0;
  int push_n = 0;
  int pop_a_n = 0;
  int pop_b_n = 0;
  logic exp_rdy;
  logic [W-1:0] qa [$];
  logic [W-1:0] qb [$];

  ab_split_fifo #(.W_FIFO(W), .D_FIFO(D)) dut (
    .clk(clk), .rst(rst), .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
    .down_data_a(down_data_a), .down_valid_a(down_valid_a), .down_ready_a(down_ready_a),
    .down_data_b(down_data_b), .down_valid_b(down_valid_b), .down_ready_b(down_ready_b)
`ifdef AB_SPLIT_FIFO_COUNT_EN
    , .count_a(count_a), .count_b(count_b)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Scoreboard: values seen here are the pre-edge state, so handshakes are decided from the model queues.
  always @(posedge clk) begin
    if (!rst) begin
      qa.delete();
      qb.delete();
    end else begin
      exp_rdy = qa.size() < D && qb.size() < D;
      checks += 3;
      if (up_ready !== exp_rdy) begin errors++; $display("FAIL sb_up_ready got=%b exp=%b t=%0t", up_ready, exp_rdy, $time); end
      if (down_valid_a !== (qa.size() != 0)) begin errors++; $display("FAIL sb_valid_a got=%b exp=%b t=%0t", down_valid_a, qa.size() != 0, $time); end
      if (down_valid_b !== (qb.size() != 0)) begin errors++; $display("FAIL sb_valid_b got=%b exp=%b t=%0t", down_valid_b, qb.size() != 0, $time); end
      if (qa.size() != 0 && down_ready_a) begin
        checks++;
        if (down_data_a !== qa[0]) begin errors++; $display("FAIL sb_data_a got=%h exp=%h t=%0t", down_data_a, qa[0], $time); end
        void'(qa.pop_front());
        pop_a_n++;
      end
      if (qb.size() != 0 && down_ready_b) begin
        checks++;
        if (down_data_b !== qb[0]) begin errors++; $display("FAIL sb_data_b got=%h exp=%h t=%0t", down_data_b, qb[0], $time); end
        void'(qb.pop_front());
        pop_b_n++;
      end
      if (up_valid && exp_rdy) begin
        qa.push_back(up_data[2*W-1:W]);
        qb.push_back(up_data[W-1:0]);
        push_n++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    up_valid = 0;
    down_ready_a = 1;
    down_ready_b = 1;
    for (int i = 0; i < 40 && (qa.size() != 0 || qb.size() != 0); i++) tick();
  endtask

  task automatic test_reset();
    rst = 0;
    up_valid = 0;
    up_data = '0;
    down_ready_a = 0;
    down_ready_b = 0;
    tick();
    tick();
    checks += 3;
    if (up_ready !== 1'b1) begin errors++; $display("FAIL rst_up_ready got=%b exp=1", up_ready); end
    if (down_valid_a !== 1'b0) begin errors++; $display("FAIL rst_valid_a got=%b exp=0", down_valid_a); end
    if (down_valid_b !== 1'b0) begin errors++; $display("FAIL rst_valid_b got=%b exp=0", down_valid_b); end
    rst = 1;
    tick();
    checks += 2;
    if (up_ready !== 1'b1) begin errors++; $display("FAIL post_rst_up_ready got=%b exp=1", up_ready); end
    if (down_valid_a !== 1'b0 || down_valid_b !== 1'b0) begin errors++; $display("FAIL post_rst_valid got=%b%b exp=00", down_valid_a, down_valid_b); end
`ifdef AB_SPLIT_FIFO_COUNT_EN
    checks++;
    if (count_a !== '0 || count_b !== '0) begin errors++; $display("FAIL rst_count got=%0d/%0d exp=0/0", count_a, count_b); end
`endif
  endtask

  task automatic test_single();
    up_data = 16'hA55A;
    up_valid = 1;
    down_ready_a = 1;
    down_ready_b = 1;
    tick();
    up_valid = 0;
    checks += 3;
    if (down_valid_a !== 1'b1 || down_valid_b !== 1'b1) begin errors++; $display("FAIL single_valid got=%b%b exp=11", down_valid_a, down_valid_b); end
    if (down_data_a !== 8'hA5) begin errors++; $display("FAIL single_data_a got=%h exp=a5", down_data_a); end
    if (down_data_b !== 8'h5A) begin errors++; $display("FAIL single_data_b got=%h exp=5a", down_data_b); end
    tick();
    checks++;
    if (down_valid_a !== 1'b0 || down_valid_b !== 1'b0) begin errors++; $display("FAIL single_empty got=%b%b exp=00", down_valid_a, down_valid_b); end
  endtask

  task automatic test_fill_b();
    int n;
    down_ready_a = 1;
    down_ready_b = 0;
    for (int i = 0; i < D; i++) begin
      up_data = {8'(8'h10 + i), 8'(8'h30 + i)};
      up_valid = 1;
      tick();
    end
    checks += 2;
    if (up_ready !== 1'b0) begin errors++; $display("FAIL full_up_ready got=%b exp=0", up_ready); end
    if (down_valid_b !== 1'b1) begin errors++; $display("FAIL full_valid_b got=%b exp=1", down_valid_b); end
`ifdef AB_SPLIT_FIFO_COUNT_EN
    checks++;
    if (count_b !== 4'(D)) begin errors++; $display("FAIL full_count_b got=%0d exp=%0d", count_b, D); end
`endif
    up_data = 16'hC3D4;
    n = push_n;
    repeat (3) tick();
    checks++;
    if (push_n != n || up_ready !== 1'b0) begin errors++; $display("FAIL full_hold pushes=%0d up_ready=%b exp=0/0", push_n - n, up_ready); end
    // b pops in the same cycle it is still full: the held word must wait one more edge.
    down_ready_b = 1;
    for (int i = 0; i < 20 && push_n == n; i++) tick();
    up_valid = 0;
    checks++;
    if (push_n != n + 1) begin errors++; $display("FAIL full_accept_once pushes=%0d exp=1", push_n - n); end
    drain();
    checks++;
    if (down_valid_a !== 1'b0 || down_valid_b !== 1'b0) begin errors++; $display("FAIL fill_drain got=%b%b exp=00", down_valid_a, down_valid_b); end
  endtask

  task automatic test_random();
    int n0, pa0, pb0;
    n0 = push_n;
    pa0 = pop_a_n;
    pb0 = pop_b_n;
    up_data = 16'($urandom);
    up_valid = 1;
    for (int i = 0; i < 400 && push_n - n0 < 20; i++) begin
      down_ready_a = 1'($urandom_range(0, 1));
      down_ready_b = 1'($urandom_range(0, 1));
      tick();
      if (push_n != n0 + i && push_n - n0 >= 20) up_valid = 0;
      up_data = 16'($urandom);
    end
    up_valid = 0;
    checks++;
    if (push_n - n0 != 20) begin errors++; $display("FAIL rand_pushes got=%0d exp=20", push_n - n0); end
    drain();
    checks += 2;
    if (pop_a_n - pa0 != 20) begin errors++; $display("FAIL rand_pops_a got=%0d exp=20", pop_a_n - pa0); end
    if (pop_b_n - pb0 != 20) begin errors++; $display("FAIL rand_pops_b got=%0d exp=20", pop_b_n - pb0); end
  endtask

  task automatic test_mid_reset();
    down_ready_a = 0;
    down_ready_b = 0;
    for (int i = 0; i < 3; i++) begin
      up_data = {8'(8'h70 + i), 8'(8'h90 + i)};
      up_valid = 1;
      tick();
    end
    up_valid = 0;
    checks++;
    if (down_valid_a !== 1'b1 || down_valid_b !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%b%b exp=11", down_valid_a, down_valid_b); end
    rst = 0;
    #1;
    checks += 2;
    if (down_valid_a !== 1'b0 || down_valid_b !== 1'b0) begin errors++; $display("FAIL mid_async_valid got=%b%b exp=00", down_valid_a, down_valid_b); end
    if (up_ready !== 1'b1) begin errors++; $display("FAIL mid_async_up_ready got=%b exp=1", up_ready); end
    tick();
    rst = 1;
    tick();
    up_data = 16'h0102;
    up_valid = 1;
    down_ready_a = 1;
    down_ready_b = 1;
    tick();
    up_valid = 0;
    checks += 2;
    if (down_valid_a !== 1'b1 || down_data_a !== 8'h01) begin errors++; $display("FAIL mid_first_a got=%b/%h exp=1/01", down_valid_a, down_data_a); end
    if (down_valid_b !== 1'b1 || down_data_b !== 8'h02) begin errors++; $display("FAIL mid_first_b got=%b/%h exp=1/02", down_valid_b, down_data_b); end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_b();
    test_random();
    test_mid_reset();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
